sram_sp_arb: RTL and testbench

SRAM_SP_ARB -- requirements
Module: sram_sp_arb

---
 rtl/sram_sp_arb_pkg.sv | 11 +
 rtl/sram_sp_arb_rsp_fifo.sv | 43 ++++
 rtl/sram_sp_arb.sv | 155 +++++++++++++++
 tb/tb_sram_sp_arb.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sp_arb_pkg.sv
// Shared constants and state encoding for the single-port SRAM arbiter.
// The optional power-up zero sweep is enabled by defining SRAM_SP_ARB_INIT_EN.
package sram_sp_arb_pkg;
    localparam int DATA_W_DEF = 128;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/sram_sp_arb_rsp_fifo.sv
// Two-entry read-response FIFO; push and pop in one cycle keep the count unchanged.
module sram_sp_arb_rsp_fifo
    import sram_sp_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // Storage carries no reset; an empty count makes its contents irrelevant.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/sram_sp_arb.sv
// Round-robin arbiter sharing one single-port SRAM between a write and a read
// channel, with credit-limited reads; SRAM_SP_ARB_INIT_EN adds a zero-fill sweep.
module sram_sp_arb
    import sram_sp_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RSTB,
    // All channels: a transfer happens on a rising edge where valid and ready
    // are both high; ready never looks at the same channel's valid.
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              sram_ceb,
    output logic              sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,
    output logic              init_done,
    output state_e            dbg_state
);
    state_e            state;
    state_e            state_nxt;
    logic              run;
    logic              sweep;
    logic              in_flight;
    logic              prio_rd;
    logic              rd_elig;
    logic              rd_go;
    logic              wr_go;
    logic              contended;
    logic [1:0]        fifo_count;
    logic [1:0]        occupancy;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_push;
    logic              fifo_pop;

`ifdef SRAM_SP_ARB_INIT_EN
    logic [ADDR_W-1:0] init_addr;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            init_addr <= '0;
        end else if (state == INIT) begin
            init_addr <= init_addr + 1'b1;
        end
    end

    // Gated by RSTB so the SRAM stays deselected while reset is held.
    assign sweep = (state == INIT) && RSTB;
`else
    assign sweep = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef SRAM_SP_ARB_INIT_EN
            INIT:    if (&init_addr) state_nxt = RUN;
`else
            INIT:    state_nxt = RUN;
`endif
            RUN:     state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign run       = (state == RUN);
    assign init_done = run;
    assign dbg_state = state;

    // A read needs a free response slot counting the one still in the SRAM pipe.
    assign occupancy = fifo_count + {1'b0, in_flight};
    assign rd_elig   = run && (occupancy < 2'd2);
    assign rd_ready  = rd_elig && !(wr_valid && !prio_rd);
    assign wr_ready  = run && !(rd_valid && rd_elig && prio_rd);
    assign rd_go     = rd_valid && rd_ready;
    assign wr_go     = wr_valid && wr_ready;
    assign contended = rd_valid && wr_valid && rd_elig;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            in_flight <= 1'b0;
            prio_rd   <= 1'b1;
        end else begin
            in_flight <= rd_go;
            if (contended) prio_rd <= ~prio_rd;
        end
    end

    always_comb begin
        sram_ceb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_d   = '0;
        if (sweep) begin
`ifdef SRAM_SP_ARB_INIT_EN
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = init_addr;
`endif
        end else if (wr_go) begin
            sram_ceb = 1'b0;
            sram_web = 1'b0;
            sram_a   = wr_addr;
            sram_d   = wr_data;
        end else if (rd_go) begin
            sram_ceb = 1'b0;
            sram_a   = rd_addr;
        end
    end

    // Q bypasses the FIFO when it is empty and the consumer takes it at once.
    assign fifo_push = in_flight && !((fifo_count == 2'd0) && rsp_ready);
    assign fifo_pop  = rsp_ready && (fifo_count != 2'd0);
    assign rsp_valid = in_flight || (fifo_count != 2'd0);

    always_comb begin
        rsp_data = '0;
        if (fifo_count != 2'd0) begin
            rsp_data = fifo_head;
        end else if (in_flight) begin
            rsp_data = sram_q;
        end
    end

    sram_sp_arb_rsp_fifo #(
        .DATA_W(DATA_W)
    ) u_rsp_fifo (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .push     (fifo_push),
        .push_data(sram_q),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_sram_sp_arb.sv
// Directed, table-driven bench for sram_sp_arb with a behavioural SRAM model.
// Build with SRAM_SP_ARB_INIT_EN defined to exercise the zero-fill sweep.
module tb_sram_sp_arb;
    import sram_sp_arb_pkg::*;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 4;

    localparam logic [DATA_W-1:0] D_A5 = {16{8'hA5}};
    localparam logic [DATA_W-1:0] D_11 = {16{8'h11}};
    localparam logic [DATA_W-1:0] D_22 = {16{8'h22}};
    localparam logic [DATA_W-1:0] D_33 = {16{8'h33}};

    typedef struct {
        logic              wv;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic              rv;
        logic [ADDR_W-1:0] ra;
        logic              rr;
        logic              e_wrdy;
        logic              e_rrdy;
        logic              e_ceb;
        logic              e_web;
        logic [ADDR_W-1:0] e_a;
        logic              e_rv;
        logic [DATA_W-1:0] e_rd;
    } vec_t;

    logic              CLK;
    logic              RSTB;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              sram_ceb;
    logic              sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_d;
    logic [DATA_W-1:0] sram_q;
    logic              init_done;
    state_e            dbg_state;

    logic [DATA_W-1:0] sram_mem [2**ADDR_W];
    vec_t              vq[$];
    int                tests = 0;
    int                fails = 0;

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // single-port SRAM with registered Q
    always @(posedge CLK) begin
        if (!sram_ceb) begin
            if (!sram_web) sram_mem[sram_a] <= sram_d;
            else           sram_q <= sram_mem[sram_a];
        end
    end

    sram_sp_arb #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .CLK      (CLK),
        .RSTB     (RSTB),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_addr  (rd_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .sram_ceb (sram_ceb),
        .sram_web (sram_web),
        .sram_a   (sram_a),
        .sram_d   (sram_d),
        .sram_q   (sram_q),
        .init_done(init_done),
        .dbg_state(dbg_state)
    );

    // scoreboard helper
    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_valid  = 1'b0;
        rd_addr   = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic add_vec(input logic wv, input logic [ADDR_W-1:0] wa,
                           input logic [DATA_W-1:0] wd, input logic rv,
                           input logic [ADDR_W-1:0] ra, input logic rr,
                           input logic e_wrdy, input logic e_rrdy,
                           input logic e_ceb, input logic e_web,
                           input logic [ADDR_W-1:0] e_a, input logic e_rv,
                           input logic [DATA_W-1:0] e_rd);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.rv = rv; v.ra = ra; v.rr = rr;
        v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_ceb = e_ceb; v.e_web = e_web;
        v.e_a = e_a; v.e_rv = e_rv; v.e_rd = e_rd;
        vq.push_back(v);
    endtask

    // Release reset at a falling edge and follow the block into RUN.
    task automatic release_reset();
        @(negedge CLK);
        RSTB = 1'b1;
        #1;
        check("init_done_after_release", init_done, 1'b0);
`ifdef SRAM_SP_ARB_INIT_EN
        for (int i = 0; i < 2**ADDR_W; i++) begin
            if (i != 0) begin
                @(negedge CLK);
                #1;
            end
            check($sformatf("sweep_ceb_%0d", i), sram_ceb, 1'b0);
            check($sformatf("sweep_web_%0d", i), sram_web, 1'b0);
            check($sformatf("sweep_a_%0d", i), sram_a, i);
            check($sformatf("sweep_d_%0d", i), sram_d, '0);
            check($sformatf("sweep_wr_ready_%0d", i), wr_ready, 1'b0);
            check($sformatf("sweep_rd_ready_%0d", i), rd_ready, 1'b0);
            check($sformatf("sweep_init_done_%0d", i), init_done, 1'b0);
        end
`else
        check("ceb_first_cycle", sram_ceb, 1'b1);
`endif
        @(negedge CLK);
        #1;
        check("init_done_run", init_done, 1'b1);
        check("dbg_state_run", dbg_state, RUN);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, wr_ready, 1'b0);
        check({tag, "_rd_ready"}, rd_ready, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check({tag, "_ceb"}, sram_ceb, 1'b1);
        check({tag, "_web"}, sram_web, 1'b1);
        check({tag, "_init_done"}, init_done, 1'b0);
    endtask

    initial begin
        logic saw_rsp;
        RSTB = 1'b0;
        drive_idle();
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        release_reset();

`ifdef SRAM_SP_ARB_INIT_EN
        // the sweep left every word at zero
        @(negedge CLK);
        rd_valid = 1'b1;
        rd_addr  = 4'd9;
        #1;
        check("init_rd9_ready", rd_ready, 1'b1);
        @(negedge CLK);
        rd_valid = 1'b0;
        #1;
        check("init_rd9_valid", rsp_valid, 1'b1);
        check("init_rd9_data", rsp_data, '0);
`endif

        //      wv wa   wd    rv ra   rr | wrdy rrdy ceb web a  rv  rd
        add_vec(1, 4'd3, D_A5, 0, 4'd0, 1,  1,   1,   0,  0, 3, 0, '0);
        add_vec(0, 4'd0, '0,   1, 4'd3, 1,  0,   1,   0,  1, 3, 0, '0);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   1,   1,  1, 0, 1, D_A5);
        add_vec(1, 4'd5, D_11, 1, 4'd3, 1,  0,   1,   0,  1, 3, 0, '0);
        add_vec(1, 4'd5, D_11, 1, 4'd3, 1,  1,   0,   0,  0, 5, 1, D_A5);
        add_vec(1, 4'd6, D_22, 1, 4'd5, 1,  0,   1,   0,  1, 5, 0, '0);
        add_vec(1, 4'd6, D_22, 1, 4'd5, 1,  1,   0,   0,  0, 6, 1, D_11);
        add_vec(0, 4'd0, '0,   1, 4'd6, 0,  0,   1,   0,  1, 6, 0, '0);
        add_vec(0, 4'd0, '0,   1, 4'd3, 0,  0,   1,   0,  1, 3, 1, D_22);
        add_vec(0, 4'd0, '0,   1, 4'd5, 0,  1,   0,   1,  1, 0, 1, D_22);
        add_vec(1, 4'd7, D_33, 1, 4'd5, 0,  1,   0,   0,  0, 7, 1, D_22);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   0,   1,  1, 0, 1, D_22);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   1,   1,  1, 0, 1, D_A5);
        add_vec(0, 4'd0, '0,   1, 4'd7, 1,  0,   1,   0,  1, 7, 0, '0);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   1,   1,  1, 0, 1, D_33);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   1,   1,  1, 0, 0, '0);
        add_vec(0, 4'd0, '0,   1, 4'd3, 0,  0,   1,   0,  1, 3, 0, '0);
        add_vec(0, 4'd0, '0,   1, 4'd5, 0,  0,   1,   0,  1, 5, 1, D_A5);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   0,   1,  1, 0, 1, D_A5);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   1,   1,  1, 0, 1, D_11);
        add_vec(0, 4'd0, '0,   0, 4'd0, 1,  1,   1,   1,  1, 0, 0, '0);

        foreach (vq[i]) begin
            @(negedge CLK);
            wr_valid  = vq[i].wv;
            wr_addr   = vq[i].wa;
            wr_data   = vq[i].wd;
            rd_valid  = vq[i].rv;
            rd_addr   = vq[i].ra;
            rsp_ready = vq[i].rr;
            #1;
            check($sformatf("v%0d_wr_ready", i), wr_ready, vq[i].e_wrdy);
            check($sformatf("v%0d_rd_ready", i), rd_ready, vq[i].e_rrdy);
            check($sformatf("v%0d_ceb", i), sram_ceb, vq[i].e_ceb);
            check($sformatf("v%0d_web", i), sram_web, vq[i].e_web);
            check($sformatf("v%0d_a", i), sram_a, vq[i].e_a);
            check($sformatf("v%0d_d", i), sram_d,
                  (!vq[i].e_ceb && !vq[i].e_web) ? vq[i].wd : '0);
            check($sformatf("v%0d_rsp_valid", i), rsp_valid, vq[i].e_rv);
            if (vq[i].e_rv) begin
                check($sformatf("v%0d_rsp_data", i), rsp_data, vq[i].e_rd);
            end
        end

        // reset lands while a read is in flight: its response must vanish
        @(negedge CLK);
        drive_idle();
        rd_valid = 1'b1;
        rd_addr  = 4'd3;
        #1;
        check("rst_rd_ready", rd_ready, 1'b1);
        @(negedge CLK);
        drive_idle();
        RSTB = 1'b0;
        #1;
        check_reset_outputs("midrst");
        saw_rsp = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        release_reset();
        repeat (6) begin
            @(negedge CLK);
            #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("no_rsp_after_reset", saw_rsp, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
